l2_cacheline_adaptor: RTL and testbench

- Downstream neighbour of the L2 cache controller; sits between the L2 and physical memory.
- Converts a single 256-bit cacheline read or write request from the L2 into a 4-beat, 64-bit burst transaction on the memory port.
- Returns one 256-bit line and a single-cycle response to the L2.
- Latches the request address and, for writes, the line, so the L2 datapath may change once the request is accepted.

---
 rtl/l2_cacheline_adaptor.sv | 176 +++++++++++++++++
 tb/tb_l2_cacheline_adaptor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
//   Sits between the L2 cache controller and physical memory. Turns one
//   LINE_WIDTH-bit line read/write from the L2 into a BURST_LEN-beat burst of
//   BEAT_WIDTH-bit beats on the memory port, and returns the assembled line
//   plus a one-cycle completion pulse to the L2.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   address_i       line address from the L2
//   read_i/write_i  L2 line request (level, held until resp_o)
//   line_i          writeback line, sampled at acceptance
//   line_o          assembled read line (partial beats visible while reading)
//   resp_o          one-cycle completion pulse to the L2
//   burst_i         memory read beat
//   burst_o         memory write beat (0 outside a write burst)
//   address_o       line-aligned burst address (0 when idle)
//   read_o/write_o  memory burst request
//   resp_i          memory beat strobe, one beat per high cycle
//
// Optional: define L2_CACHELINE_ADAPTOR_STATS_EN to add rd_burst_cnt_o and
// wr_burst_cnt_o, counters of completed read/write bursts.
module l2_cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
`ifdef L2_CACHELINE_ADAPTOR_STATS_EN
  ,
  output logic [31:0]           rd_burst_cnt_o,
  output logic [31:0]           wr_burst_cnt_o
`endif
);

  localparam int unsigned OFFS_W = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W  = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  rline_q;   // read line, drives line_o
  logic [LINE_WIDTH-1:0]  wline_q;   // writeback line; kept apart so writes never disturb line_o
  logic                   resp_q;
  logic                   read_q;
  logic                   write_q;

  logic [ADDR_WIDTH-1:0]  addr_aligned_d;
  logic                   last_beat_d;

  assign addr_aligned_d = {address_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
  assign last_beat_d    = resp_i && (cnt_q == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rline_q <= '0;
      wline_q <= '0;
      resp_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Read takes priority when both requests are raised together.
          if (read_i) begin
            addr_q  <= addr_aligned_d;
            read_q  <= 1'b1;
            state_q <= RD;
          end else if (write_i) begin
            addr_q  <= addr_aligned_d;
            wline_q <= line_i;
            write_q <= 1'b1;
            state_q <= WR;
          end
        end
        RD: begin
          if (resp_i) begin
            for (int unsigned i = 0; i < BURST_LEN; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                rline_q[i*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
              end
            end
            if (last_beat_d) begin
              cnt_q   <= '0;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WR: begin
          if (resp_i) begin
            if (last_beat_d) begin
              cnt_q   <= '0;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Beat mux for the write path, selected directly by the beat counter.
  always_comb begin
    burst_o = '0;
    if (state_q == WR) begin
      for (int unsigned i = 0; i < BURST_LEN; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          burst_o = wline_q[i*BEAT_WIDTH +: BEAT_WIDTH];
        end
      end
    end
  end

  assign line_o    = rline_q;
  assign resp_o    = resp_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign address_o = (read_q || write_q) ? addr_q : '0;

`ifdef L2_CACHELINE_ADAPTOR_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Counted on the last beat so the new value is visible in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_q == RD && last_beat_d) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (state_q == WR && last_beat_d) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_burst_cnt_o = rd_cnt_q;
  assign wr_burst_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
module tb_l2_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int BL = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address_i = '0;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic [LW-1:0] line_o;
  logic          resp_o;
  logic [BW-1:0] burst_i = '0;
  logic [BW-1:0] burst_o;
  logic [AW-1:0] address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i = 1'b0;
`ifdef L2_CACHELINE_ADAPTOR_STATS_EN
  logic [31:0]   rd_burst_cnt_o;
  logic [31:0]   wr_burst_cnt_o;
`endif

  l2_cacheline_adaptor #(
    .LINE_WIDTH(LW),
    .BEAT_WIDTH(BW),
    .BURST_LEN (BL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
`ifdef L2_CACHELINE_ADAPTOR_STATS_EN
    ,
    .rd_burst_cnt_o(rd_burst_cnt_o),
    .wr_burst_cnt_o(wr_burst_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Reference state: what line_o must hold, and completed-burst tallies.
  logic [LW-1:0] m_line = '0;
  int unsigned   m_rd_cnt = 0;
  int unsigned   m_wr_cnt = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_resp_o"}, resp_o, 1'b0);
    check_eq({tag, "_read_o"}, read_o, 1'b0);
    check_eq({tag, "_write_o"}, write_o, 1'b0);
    check_eq({tag, "_address_o"}, address_o, '0);
    check_eq({tag, "_burst_o"}, burst_o, '0);
  endtask

  // One L2 transaction, entered and left in an IDLE cycle at posedge+1.
  // mode: 0 = no gaps, 1 = random gaps, 2 = fixed strobe pattern 1,0,0,1,1,0,1
  task automatic run_txn(input bit rq, input bit wq, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input logic [LW-1:0] rdata,
                         input int mode);
    logic [BW-1:0] beats[$];
    logic [LW-1:0] sh;
    bit            pattern[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit            is_read = rq;
    bit            done = 1'b0;
    bit            s;
    int            beat = 0;
    int            gaps = 0;
    int            pidx = 0;
    int            cyc;
    read_i    = rq;
    write_i   = wq;
    address_i = addr;
    line_i    = wdata;
    resp_i    = 1'(($urandom & 1));   // strobes while idle must be ignored
    burst_i   = BW'({$urandom, $urandom});
    tick();
    cyc = 1;
    // L2 datapath may move once the request is accepted.
    address_i = $urandom;
    line_i    = rand_line();
    while (!done && cyc < 200) begin
      if (resp_o) begin
        check_eq("latency", cyc, BL + gaps + 1);
        if (is_read) begin
          m_line = {beats[3], beats[2], beats[1], beats[0]};
          m_rd_cnt++;
        end else begin
          m_wr_cnt++;
        end
        check_eq("line_o_done", line_o, m_line);
        check_eq("done_read_o", read_o, 1'b0);
        check_eq("done_write_o", write_o, 1'b0);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'(($urandom & 1));  // ignored in DONE
        tick();
        check_idle_outputs("after_done");
        check_eq("line_o_stable", line_o, m_line);
        done = 1'b1;
      end else begin
        check_eq("read_o", read_o, is_read);
        check_eq("write_o", write_o, !is_read);
        check_eq("address_o", address_o, addr & ~32'h1f);
        if (!is_read) check_eq("line_o_hold_wr", line_o, m_line);
        else          check_eq("burst_o_rd", burst_o, '0);
        case (mode)
          0:       s = 1'b1;
          1:       s = ($urandom_range(0, 3) != 0);
          default: begin
            s = (pidx < 7) ? pattern[pidx] : 1'b1;
            pidx++;
          end
        endcase
        resp_i  = s;
        burst_i = s ? rdata[beat*BW +: BW] : BW'({$urandom, $urandom});
        if (s) begin
          if (!is_read) begin
            sh = wdata >> (BW * beat);
            check_eq("burst_o", burst_o, sh[BW-1:0]);
          end else begin
            beats.push_back(burst_i);
          end
          beat++;
        end else begin
          gaps++;
        end
        tick();
        cyc++;
      end
    end
    check_eq("timeout", done, 1'b1);
    resp_i = 1'b0;
  endtask

  task automatic reset_mid_read(input logic [AW-1:0] addr);
    read_i    = 1'b1;
    address_i = addr;
    resp_i    = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = BW'({$urandom, $urandom});
      tick();
    end
    check_eq("pre_reset_read_o", read_o, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_read_o", read_o, 1'b0);
    check_eq("rst_line_o", line_o, '0);
    check_eq("rst_resp_o", resp_o, 1'b0);
    check_eq("rst_address_o", address_o, '0);
    m_line   = '0;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
    read_i = 1'b0;
    resp_i = 1'b0;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle_outputs("post_rst");
      check_eq("post_rst_line_o", line_o, '0);
    end
  endtask

  initial begin
    logic [LW-1:0] tp_line;
    logic [LW-1:0] wd;
    int            op;
    tp_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_line_o", line_o, '0);
    rst = 1'b0;
    tick();

    // Directed read, no gaps.
    run_txn(1'b1, 1'b0, 32'h0000_1234, rand_line(), tp_line, 0);
    check_eq("tp_read_line", line_o, tp_line);

    // Back-to-back write with gapped strobes.
    wd = rand_line();
    run_txn(1'b0, 1'b1, 32'hdead_beef, wd, rand_line(), 2);
    check_eq("tp_write_keeps_line", line_o, tp_line);

    // Simultaneous request: read wins.
    run_txn(1'b1, 1'b1, 32'h8000_0040, rand_line(), rand_line(), 1);

    // Abort, then a normal read with fresh data.
    reset_mid_read(32'h0000_2000);
    run_txn(1'b1, 1'b0, 32'h0000_2000, rand_line(), rand_line(), 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      run_txn(op != 1, op != 0, $urandom, rand_line(), rand_line(), int'($urandom_range(0, 1)));
    end

`ifdef L2_CACHELINE_ADAPTOR_STATS_EN
    check_eq("rd_burst_cnt", rd_burst_cnt_o, m_rd_cnt);
    check_eq("wr_burst_cnt", wr_burst_cnt_o, m_wr_cnt);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
